// File: rtl/rgb565_grayscale_pipe_ise_if.sv
// rtl/rgb565_grayscale_pipe_ise_if.sv - custom-instruction bus between CPU and the grayscale unit
interface rgb565_grayscale_pipe_ise_if;
  logic        start;
  logic [7:0]  iseId;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, iseId, valueA, valueB,
    input  done, result
  );

  modport slave (
    input  start, iseId, valueA, valueB,
    output done, result
  );
endinterface

// File: rtl/rgb565_grayscale_pipe_ise.sv
// rtl/rgb565_grayscale_pipe_ise.sv - 2-stage RGB565 to 8-bit luma custom instruction, up to 4 pixels
module rgb565_grayscale_pipe_ise #(
  parameter logic [7:0] customId   = 8'h00,
  parameter int         NUM_PIXELS = 2,
  parameter int         ROUND      = 1
) (
  input logic                        clock,
  input logic                        nReset,
  rgb565_grayscale_pipe_ise_if.slave bus
);

  localparam logic [16:0] RND_ADD = (ROUND != 0) ? 17'd128 : 17'd0;

  logic        accept;
  logic [15:0] pix [4];

  logic [15:0] prod_r_d [4];
  logic [15:0] prod_g_d [4];
  logic [15:0] prod_b_d [4];
  logic [15:0] prod_r_q [4];
  logic [15:0] prod_g_q [4];
  logic [15:0] prod_b_q [4];
  logic        s1_valid_d;
  logic        s1_valid_q;

  logic [16:0] sum [4];
  logic [31:0] packed_d;
  logic [31:0] packed_q;
  logic        s2_valid_q;

  assign accept     = bus.start && (bus.iseId == customId);
  assign s1_valid_d = accept;

  assign pix[0] = bus.valueA[15:0];
  assign pix[1] = bus.valueA[31:16];
  assign pix[2] = bus.valueB[15:0];
  assign pix[3] = bus.valueB[31:16];

  // Channels widen to 8 bits by replicating their MSBs so full-scale maps to 255.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      prod_r_d[i] = '0;
      prod_g_d[i] = '0;
      prod_b_d[i] = '0;
      if (i < NUM_PIXELS) begin
        prod_r_d[i] = 16'd54  * {8'd0, pix[i][15:11], pix[i][15:13]};
        prod_g_d[i] = 16'd183 * {8'd0, pix[i][10:5],  pix[i][10:9]};
        prod_b_d[i] = 16'd19  * {8'd0, pix[i][4:0],   pix[i][4:2]};
      end
    end
  end

  // Weights sum to 256, so the shifted sum always fits in a byte.
  always_comb begin
    packed_d = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = {1'b0, prod_r_q[i]} + {1'b0, prod_g_q[i]} + {1'b0, prod_b_q[i]} + RND_ADD;
      if (i < NUM_PIXELS) begin
        packed_d[8*i +: 8] = 8'(sum[i] >> 8);
      end
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      packed_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        prod_r_q[i] <= '0;
        prod_g_q[i] <= '0;
        prod_b_q[i] <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s1_valid_q;
      packed_q   <= packed_d;
      for (int i = 0; i < 4; i++) begin
        prod_r_q[i] <= prod_r_d[i];
        prod_g_q[i] <= prod_g_d[i];
        prod_b_q[i] <= prod_b_d[i];
      end
    end
  end

  // Result is OR-combined with other units on the bus, so it must be zero when idle.
  assign bus.done   = s2_valid_q;
  assign bus.result = s2_valid_q ? packed_q : 32'h0;

endmodule

// File: tb/tb_rgb565_grayscale_pipe_ise.sv
// tb/tb_rgb565_grayscale_pipe_ise.sv - directed-vector bench over several NUM_PIXELS/ROUND configurations
module tb_rgb565_grayscale_pipe_ise;

  logic        clock;
  logic        nReset;
  logic        start;
  logic [7:0]  iseId;
  logic [31:0] valueA;
  logic [31:0] valueB;

  wire  [4:0]  done_w;
  wire  [31:0] res_w [5];

  int checks;
  int errors;

  // 0: NP1/R1  1: NP1/R0  2: NP4/R1  3: NP4/R0  4: NP2/R1
  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int NP = (g < 2) ? 1 : ((g < 4) ? 4 : 2);
    localparam int RD = (g == 1 || g == 3) ? 0 : 1;
    rgb565_grayscale_pipe_ise_if bus ();
    assign bus.start  = start;
    assign bus.iseId  = iseId;
    assign bus.valueA = valueA;
    assign bus.valueB = valueB;
    assign done_w[g]  = bus.done;
    assign res_w[g]   = bus.result;
    rgb565_grayscale_pipe_ise #(
      .customId   (8'h00),
      .NUM_PIXELS (NP),
      .ROUND      (RD)
    ) dut (
      .clock  (clock),
      .nReset (nReset),
      .bus    (bus)
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    iseId  = 8'h00;
    valueA = 32'hFFFF_FFFF;
    valueB = 32'hFFFF_FFFF;
    for (int c = 0; c < 4; c++) begin
      start = c[0];
      step();
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (done_w[k] !== 1'b0 || res_w[k] !== 32'h0) begin
          errors++;
          $display("FAIL reset_hold dut%0d cyc%0d done=%b result=%h expected done=0 result=00000000", k, c, done_w[k], res_w[k]);
        end
      end
    end
    start  = 1'b0;
    nReset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (done_w[k] !== 1'b0 || res_w[k] !== 32'h0) begin
          errors++;
          $display("FAIL idle dut%0d cyc%0d done=%b result=%h expected done=0 result=00000000", k, c, done_w[k], res_w[k]);
        end
      end
    end
  endtask

  task automatic test_single_pixel();
    start  = 1'b1;
    iseId  = 8'h00;
    valueA = 32'h0000_F800;
    valueB = 32'h0;
    step();
    start = 1'b0;
    checks++;
    if (done_w[0] !== 1'b0 || done_w[1] !== 1'b0) begin
      errors++;
      $display("FAIL single_t1 done=%b/%b expected 0/0", done_w[0], done_w[1]);
    end
    step();
    checks++;
    if (done_w[0] !== 1'b1 || res_w[0] !== 32'h0000_0036) begin
      errors++;
      $display("FAIL single_round done=%b result=%h expected 1 00000036", done_w[0], res_w[0]);
    end
    checks++;
    if (done_w[1] !== 1'b1 || res_w[1] !== 32'h0000_0035) begin
      errors++;
      $display("FAIL single_trunc done=%b result=%h expected 1 00000035", done_w[1], res_w[1]);
    end
    checks++;
    if (res_w[2] !== 32'h0000_0036) begin
      errors++;
      $display("FAIL single_np4 result=%h expected 00000036", res_w[2]);
    end
    step();
    checks++;
    if (done_w[0] !== 1'b0 || res_w[0] !== 32'h0) begin
      errors++;
      $display("FAIL single_t3 done=%b result=%h expected 0 00000000", done_w[0], res_w[0]);
    end
  endtask

  task automatic test_four_pixels();
    start  = 1'b1;
    iseId  = 8'h00;
    valueA = 32'h07E0_F800;
    valueB = 32'h001F_FFFF;
    step();
    start = 1'b0;
    step();
    checks++;
    if (done_w[2] !== 1'b1 || res_w[2] !== 32'h13FF_B636) begin
      errors++;
      $display("FAIL four_round done=%b result=%h expected 1 13FFB636", done_w[2], res_w[2]);
    end
    checks++;
    if (done_w[3] !== 1'b1 || res_w[3] !== 32'h12FF_B635) begin
      errors++;
      $display("FAIL four_trunc done=%b result=%h expected 1 12FFB635", done_w[3], res_w[3]);
    end
    checks++;
    if (res_w[4] !== 32'h0000_B636) begin
      errors++;
      $display("FAIL four_np2 result=%h expected 0000B636", res_w[4]);
    end
    checks++;
    if (res_w[0] !== 32'h0000_0036) begin
      errors++;
      $display("FAIL four_np1 result=%h expected 00000036", res_w[0]);
    end
    step();
  endtask

  task automatic test_back_to_back();
    iseId  = 8'h00;
    valueB = 32'h0;
    start  = 1'b1;
    valueA = 32'hFFFF_0000;
    step();
    checks++;
    if (done_w[4] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_t1 done=%b expected 0", done_w[4]);
    end
    valueA = 32'h0000_0000;
    step();
    checks++;
    if (done_w[4] !== 1'b1 || res_w[4] !== 32'h0000_FF00) begin
      errors++;
      $display("FAIL b2b_r0 done=%b result=%h expected 1 0000FF00", done_w[4], res_w[4]);
    end
    valueA = 32'h001F_07E0;
    step();
    checks++;
    if (done_w[4] !== 1'b1 || res_w[4] !== 32'h0000_0000) begin
      errors++;
      $display("FAIL b2b_r1 done=%b result=%h expected 1 00000000", done_w[4], res_w[4]);
    end
    start = 1'b0;
    step();
    checks++;
    if (done_w[4] !== 1'b1 || res_w[4] !== 32'h0000_13B6) begin
      errors++;
      $display("FAIL b2b_r2 done=%b result=%h expected 1 000013B6", done_w[4], res_w[4]);
    end
    step();
    checks++;
    if (done_w[4] !== 1'b0 || res_w[4] !== 32'h0) begin
      errors++;
      $display("FAIL b2b_t5 done=%b result=%h expected 0 00000000", done_w[4], res_w[4]);
    end
  endtask

  task automatic test_id_filter();
    valueB = 32'h0;
    start  = 1'b1;
    iseId  = 8'h00;
    valueA = 32'h0000_F800;
    step();
    iseId  = 8'h01;
    valueA = 32'h0000_FFFF;
    step();
    checks++;
    if (done_w[0] !== 1'b1 || res_w[0] !== 32'h0000_0036) begin
      errors++;
      $display("FAIL id_first done=%b result=%h expected 1 00000036", done_w[0], res_w[0]);
    end
    iseId  = 8'h00;
    valueA = 32'h0000_07E0;
    step();
    start = 1'b0;
    checks++;
    if (done_w[0] !== 1'b0 || res_w[0] !== 32'h0) begin
      errors++;
      $display("FAIL id_gap done=%b result=%h expected 0 00000000", done_w[0], res_w[0]);
    end
    step();
    checks++;
    if (done_w[0] !== 1'b1 || res_w[0] !== 32'h0000_00B6) begin
      errors++;
      $display("FAIL id_second done=%b result=%h expected 1 000000B6", done_w[0], res_w[0]);
    end
    step();
  endtask

  task automatic test_reset_mid_flight();
    iseId  = 8'h00;
    valueB = 32'h0;
    valueA = 32'h0000_FFFF;
    start  = 1'b1;
    step();
    start = 1'b0;
    #2;
    nReset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (done_w[0] !== 1'b0 || res_w[0] !== 32'h0) begin
        errors++;
        $display("FAIL midrst_a cyc%0d done=%b result=%h expected 0 00000000", c, done_w[0], res_w[0]);
      end
    end
    #2;
    nReset = 1'b1;
    step();
    checks++;
    if (done_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_release done=%b expected 0", done_w[0]);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    checks++;
    if (done_w[0] !== 1'b1 || res_w[0] !== 32'h0000_00FF) begin
      errors++;
      $display("FAIL midrst_after done=%b result=%h expected 1 000000FF", done_w[0], res_w[0]);
    end
    #2;
    nReset = 1'b0;
    #1;
    checks++;
    if (done_w[0] !== 1'b0 || res_w[0] !== 32'h0) begin
      errors++;
      $display("FAIL midrst_async done=%b result=%h expected 0 00000000", done_w[0], res_w[0]);
    end
    step();
    nReset = 1'b1;
    step();
    step();
    checks++;
    if (done_w[0] !== 1'b0 || res_w[0] !== 32'h0) begin
      errors++;
      $display("FAIL midrst_final done=%b result=%h expected 0 00000000", done_w[0], res_w[0]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nReset = 1'b0;
    start  = 1'b0;
    iseId  = 8'h00;
    valueA = 32'h0;
    valueB = 32'h0;
    test_reset();
    test_single_pixel();
    test_four_pixels();
    test_back_to_back();
    test_id_filter();
    test_reset_mid_flight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
